// File: rtl/alarm_lockout_ctrl.sv
// Failure counter with timed ALARM (blinking) then LOCKOUT phases; Moore outputs, one-cycle latency, no backpressure.
// Optional ALARM_RETRIGGER_EN: an error during ALARM reloads the alarm timer and restarts the blink phase.
module alarm_lockout_ctrl #(
  parameter int CLK_HZ    = 100000000,
  parameter int MAX_FAIL  = 3,
  parameter int ALARM_SEC = 10,
  parameter int LOCK_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       error_pulse,
  input  logic       unlock_pulse,
  input  logic       admin_clr,
  output logic       alarm,
  output logic       lockout,
  output logic       blink,
  output logic [3:0] fail_cnt,
  output logic [7:0] remain_sec
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);
  localparam logic [7:0]    A_SEC    = 8'(ALARM_SEC);
  localparam logic [7:0]    L_SEC    = 8'(LOCK_SEC);

  typedef enum logic [1:0] {NORMAL, ALARM, LOCKOUT} state_t;

  state_t        state, n_state;
  logic [PW-1:0] presc, n_presc;
  logic [3:0]    n_fail;
  logic [7:0]    n_remain;
  logic          sec_tick;

  assign sec_tick = (presc == PRE_LAST);

  always_comb begin
    n_state  = state;
    n_fail   = fail_cnt;
    n_remain = remain_sec;
    n_presc  = sec_tick ? '0 : presc + 1'b1;
    case (state)
      NORMAL: begin
        n_presc = '0;
        if (unlock_pulse) begin
          n_fail = 4'd0;
        end else if (error_pulse) begin
          if (fail_cnt + 4'd1 == FAIL_MAX) begin
            n_fail   = FAIL_MAX;
            n_state  = ALARM;
            n_remain = A_SEC;
          end else begin
            n_fail = fail_cnt + 4'd1;
          end
        end
      end
      ALARM: begin
`ifdef ALARM_RETRIGGER_EN
        if (error_pulse) begin
          n_remain = A_SEC;
          n_presc  = '0;
        end else
`endif
        if (sec_tick) begin
          if (remain_sec == 8'd1) begin
            n_state  = LOCKOUT;
            n_remain = L_SEC;
            n_presc  = '0;
          end else begin
            n_remain = remain_sec - 8'd1;
          end
        end
      end
      LOCKOUT: begin
        if (sec_tick) begin
          if (remain_sec == 8'd1) begin
            n_state  = NORMAL;
            n_fail   = 4'd0;
            n_remain = 8'd0;
            n_presc  = '0;
          end else begin
            n_remain = remain_sec - 8'd1;
          end
        end
      end
      default: begin
        n_state  = NORMAL;
        n_fail   = 4'd0;
        n_remain = 8'd0;
        n_presc  = '0;
      end
    endcase
    if (admin_clr) begin
      n_state  = NORMAL;
      n_fail   = 4'd0;
      n_remain = 8'd0;
      n_presc  = '0;
    end
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= NORMAL;
      presc      <= '0;
      fail_cnt   <= 4'd0;
      remain_sec <= 8'd0;
      alarm      <= 1'b0;
      lockout    <= 1'b0;
      blink      <= 1'b0;
    end else begin
      state      <= n_state;
      presc      <= n_presc;
      fail_cnt   <= n_fail;
      remain_sec <= n_remain;
      alarm      <= (n_state == ALARM);
      lockout    <= (n_state != NORMAL);
      blink      <= (n_state == ALARM) && (n_presc < PRE_HALF);
    end
  end

endmodule

// File: tb/tb_alarm_lockout_ctrl.sv
// Directed bench for alarm_lockout_ctrl with a phase-elapsed-time reference model checked every cycle.
module tb_alarm_lockout_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int MAX_FAIL  = 3;
  localparam int ALARM_SEC = 2;
  localparam int LOCK_SEC  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       error_pulse;
  logic       unlock_pulse;
  logic       admin_clr;
  logic       alarm;
  logic       lockout;
  logic       blink;
  logic [3:0] fail_cnt;
  logic [7:0] remain_sec;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  alarm_lockout_ctrl #(
    .CLK_HZ(CLK_HZ), .MAX_FAIL(MAX_FAIL), .ALARM_SEC(ALARM_SEC), .LOCK_SEC(LOCK_SEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .error_pulse(error_pulse), .unlock_pulse(unlock_pulse),
    .admin_clr(admin_clr), .alarm(alarm), .lockout(lockout), .blink(blink),
    .fail_cnt(fail_cnt), .remain_sec(remain_sec)
  );

  always #5 clk = ~clk;

  // Reference: mode 0/1/2 = normal/alarm/lockout, m_el = cycles spent in the current phase.
  int m_mode = 0;
  int m_fail = 0;
  int m_el   = 0;

  always @(posedge clk) begin
    if (!rst_n || admin_clr) begin
      m_mode = 0; m_fail = 0; m_el = 0;
    end else if (m_mode == 0) begin
      if (unlock_pulse) m_fail = 0;
      else if (error_pulse) begin
        if (m_fail + 1 == MAX_FAIL) begin
          m_mode = 1; m_fail = MAX_FAIL; m_el = 0;
        end else m_fail = m_fail + 1;
      end
    end else if (m_mode == 1) begin
`ifdef ALARM_RETRIGGER_EN
      if (error_pulse) m_el = 0;
      else
`endif
      begin
        m_el = m_el + 1;
        if (m_el == ALARM_SEC * CLK_HZ) begin m_mode = 2; m_el = 0; end
      end
    end else begin
      m_el = m_el + 1;
      if (m_el == LOCK_SEC * CLK_HZ) begin m_mode = 0; m_fail = 0; m_el = 0; end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      logic       e_alarm, e_lock, e_blink;
      logic [3:0] e_fail;
      logic [7:0] e_rem;
      e_alarm = (m_mode == 1);
      e_lock  = (m_mode != 0);
      e_blink = (m_mode == 1) && ((m_el % CLK_HZ) < CLK_HZ / 2);
      e_fail  = 4'(m_fail);
      e_rem   = (m_mode == 1) ? 8'(ALARM_SEC - m_el / CLK_HZ) :
                (m_mode == 2) ? 8'(LOCK_SEC - m_el / CLK_HZ) : 8'd0;
      total++;
      if ({alarm, lockout, blink, fail_cnt, remain_sec} !== {e_alarm, e_lock, e_blink, e_fail, e_rem}) begin
        bad++;
        $display("FAIL model t=%0t got a=%b l=%b b=%b f=%0d r=%0d want a=%b l=%b b=%b f=%0d r=%0d",
                 $time, alarm, lockout, blink, fail_cnt, remain_sec,
                 e_alarm, e_lock, e_blink, e_fail, e_rem);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic err();
    error_pulse = 1'b1; @(negedge clk); error_pulse = 1'b0;
  endtask

  task automatic unl();
    unlock_pulse = 1'b1; @(negedge clk); unlock_pulse = 1'b0;
  endtask

  task automatic both();
    error_pulse = 1'b1; unlock_pulse = 1'b1; @(negedge clk);
    error_pulse = 1'b0; unlock_pulse = 1'b0;
  endtask

  task automatic adm();
    admin_clr = 1'b1; @(negedge clk); admin_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; error_pulse = 1'b1; unlock_pulse = 1'b0; admin_clr = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_clks(2);
    error_pulse = 1'b0; rst_n = 1'b1;
    chk("rst_fail", fail_cnt, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_remain", remain_sec, 0);
    chk("rst_blink", blink, 0);

    err(); chk("cnt1", fail_cnt, 1);
    err(); chk("cnt2", fail_cnt, 2);
    unl(); chk("cnt_clr", fail_cnt, 0);
    chk("cnt_no_alarm", alarm, 0);

    err(); err(); err();
    chk("alarm_on", alarm, 1);
    chk("alarm_lock", lockout, 1);
    chk("alarm_remain", remain_sec, 2);
    chk("alarm_fail", fail_cnt, 3);
    for (int i = 0; i < 10; i++) begin
      chk("blink_phase", blink, (i < 5) ? 1 : 0);
      @(negedge clk);
    end
    wait_clks(9);
    chk("alarm_last_cycle", alarm, 1);
    wait_clks(1);
    chk("lock_alarm", alarm, 0);
    chk("lock_lockout", lockout, 1);
    chk("lock_remain", remain_sec, 3);
    err(); unl();
    chk("lock_ign_remain", remain_sec, 3);
    chk("lock_ign_fail", fail_cnt, 3);
    wait_clks(27);
    chk("lock_last_cycle", lockout, 1);
    wait_clks(1);
    chk("normal_lock", lockout, 0);
    chk("normal_remain", remain_sec, 0);
    chk("normal_fail", fail_cnt, 0);

    err(); err(); err();
    wait_clks(10);
    chk("adm_pre_remain", remain_sec, 1);
    adm();
    chk("adm_alarm", alarm, 0);
    chk("adm_lockout", lockout, 0);
    chk("adm_fail", fail_cnt, 0);
    chk("adm_remain", remain_sec, 0);
    err(); chk("adm_then_err", fail_cnt, 1);

    err(); chk("pre_both", fail_cnt, 2);
    both();
    chk("both_fail", fail_cnt, 0);
    chk("both_alarm", alarm, 0);

    err(); err(); err();
    wait_clks(14);
    err();
`ifdef ALARM_RETRIGGER_EN
    chk("retrig_remain", remain_sec, 2);
    wait_clks(19);
    chk("retrig_still", alarm, 1);
    wait_clks(1);
    chk("retrig_end", alarm, 0);
`else
    chk("noretrig_remain", remain_sec, 1);
    wait_clks(4);
    chk("noretrig_still", alarm, 1);
    wait_clks(1);
    chk("noretrig_end", alarm, 0);
`endif
    chk("retrig_lock", lockout, 1);
    wait_clks(30);
    chk("final_lockout", lockout, 0);
    chk("final_fail", fail_cnt, 0);

    en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
